lane_traffic_ctrl: RTL and testbench

Parametrised multi-car traffic engine for the road/river section of the playfield. Drives NUM_CARS independent cars, each with its own lane, direction and step period, from one shared movement tick. Adds pause, live reload, level-based speed-up and a registered frog-collision detector. Sits between the level/game FSM (init values, run, level) and the sprite renderer and game-state logic (positions, hit).

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/car_step_unit.sv | 88 ++++++++
 rtl/lane_traffic_ctrl.sv | 99 +++++++++
 tb/tb_lane_traffic_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants, direction encoding and the saturating
// subtract that turns a car's step period and the level into its
// effective period.
package traffic_pkg;

    localparam int GRID_W = 40;
    localparam int POS_W  = 6;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    // Operand width for sat_sub; callers zero-extend narrower fields.
    localparam int SAT_W = 16;

    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/car_step_unit.sv
// car_step_unit: one car of the traffic engine.
// Holds the car position, its period counter and the registered frog
// collision flag.
//   i_Clk, i_Rst      clock, synchronous active-high reset
//   i_Load            reload position from i_Init_X/Y
//   i_Step_En         shared movement tick (already qualified by i_Run)
//   i_Init_X/Y        reload position
//   i_Dir             0 = right (+X), 1 = left (-X)
//   i_Period/i_Level  step period minus 1, and the speed-up subtracted from it
//   i_Frog_X/Y        frog cell
//   o_Car_X/Y         current position
//   o_Match           combinational: frog is on this car's cell now
//   o_Hit             o_Match registered
module car_step_unit #(
    parameter int GRID_W = traffic_pkg::GRID_W,
    parameter int POS_W  = traffic_pkg::POS_W,
    parameter int PER_W  = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Load,
    input  logic             i_Step_En,
    input  logic [POS_W-1:0] i_Init_X,
    input  logic [POS_W-1:0] i_Init_Y,
    input  logic             i_Dir,
    input  logic [PER_W-1:0] i_Period,
    input  logic [PER_W-1:0] i_Level,
    input  logic [POS_W-1:0] i_Frog_X,
    input  logic [POS_W-1:0] i_Frog_Y,
    output logic [POS_W-1:0] o_Car_X,
    output logic [POS_W-1:0] o_Car_Y,
    output logic             o_Match,
    output logic             o_Hit
);
    import traffic_pkg::*;

    // Assumes GRID_W < 2**POS_W; "X > X_MAX" is the out-of-range test.
    localparam logic [POS_W-1:0] X_MAX = POS_W'(GRID_W - 1);

    dir_e             dir;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] eff_period;
    logic [POS_W-1:0] next_x;

    assign dir        = dir_e'(i_Dir);
    assign eff_period = PER_W'(sat_sub(SAT_W'(i_Period), SAT_W'(i_Level)));

    always_comb begin
        next_x = o_Car_X;
        if (dir == DIR_LEFT) begin
            if (o_Car_X == '0 || o_Car_X > X_MAX)
                next_x = X_MAX;
            else
                next_x = o_Car_X - 1'b1;
        end else begin
            if (o_Car_X >= X_MAX)
                next_x = '0;
            else
                next_x = o_Car_X + 1'b1;
        end
    end

    assign o_Match = (o_Car_X == i_Frog_X) && (o_Car_Y == i_Frog_Y);

    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Load) begin
            o_Car_X <= i_Init_X;
            o_Car_Y <= i_Init_Y;
            per_cnt <= '0;
        end else if (i_Step_En) begin
            if (per_cnt >= eff_period) begin
                o_Car_X <= next_x;
                per_cnt <= '0;
            end else begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

    // Collision keeps tracking through a load; only reset clears it.
    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            o_Hit <= 1'b0;
        else
            o_Hit <= o_Match;
    end

endmodule

// File: rtl/lane_traffic_ctrl.sv
// lane_traffic_ctrl: multi-car traffic engine for the road/river section.
// A shared tick counter paces NUM_CARS car_step_unit instances; each car
// has its own lane, direction and period. Also reports frog collisions.
//   i_Clk, i_Rst       clock, synchronous active-high reset
//   i_Run              1 = cars move, 0 = pause (tick counter holds)
//   i_Load             reload init positions
//   i_Level            speed-up subtracted from every period
//   i_Init_X/Y         flattened init X / lane Y per car
//   i_Dir, i_Period    per-car direction and step period minus 1
//   i_Frog_X/Y         frog cell
//   o_Car_X/Y          flattened car positions
//   o_Tick             one-cycle pulse per movement tick
//   o_Hit, o_Hit_Mask  registered collision flags
module lane_traffic_ctrl #(
    parameter int NUM_CARS     = 8,
    parameter int GRID_W       = traffic_pkg::GRID_W,
    parameter int POS_W        = traffic_pkg::POS_W,
    parameter int PER_W        = 4,
    parameter int TICK_W       = 26,
    parameter int c_TICK_COUNT = 2000000
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic                      i_Run,
    input  logic                      i_Load,
    input  logic [PER_W-1:0]          i_Level,
    input  logic [NUM_CARS*POS_W-1:0] i_Init_X,
    input  logic [NUM_CARS*POS_W-1:0] i_Init_Y,
    input  logic [NUM_CARS-1:0]       i_Dir,
    input  logic [NUM_CARS*PER_W-1:0] i_Period,
    input  logic [POS_W-1:0]          i_Frog_X,
    input  logic [POS_W-1:0]          i_Frog_Y,
    output logic [NUM_CARS*POS_W-1:0] o_Car_X,
    output logic [NUM_CARS*POS_W-1:0] o_Car_Y,
    output logic                      o_Tick,
    output logic                      o_Hit,
    output logic [NUM_CARS-1:0]       o_Hit_Mask
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(c_TICK_COUNT - 1);

    logic [TICK_W-1:0]   tick_cnt;
    logic                tick_wrap;
    logic                step_en;
    logic [NUM_CARS-1:0] match;

    assign tick_wrap = i_Run && (tick_cnt == TICK_LAST);
    // Cars step on the same edge that raises o_Tick; a load on that edge wins.
    assign step_en   = tick_wrap && !i_Load;

    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Load) begin
            tick_cnt <= '0;
            o_Tick   <= 1'b0;
        end else if (i_Run) begin
            if (tick_wrap) begin
                tick_cnt <= '0;
                o_Tick   <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
                o_Tick   <= 1'b0;
            end
        end else begin
            o_Tick <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
        car_step_unit #(
            .GRID_W (GRID_W),
            .POS_W  (POS_W),
            .PER_W  (PER_W)
        ) u_car (
            .i_Clk     (i_Clk),
            .i_Rst     (i_Rst),
            .i_Load    (i_Load),
            .i_Step_En (step_en),
            .i_Init_X  (i_Init_X[g*POS_W +: POS_W]),
            .i_Init_Y  (i_Init_Y[g*POS_W +: POS_W]),
            .i_Dir     (i_Dir[g]),
            .i_Period  (i_Period[g*PER_W +: PER_W]),
            .i_Level   (i_Level),
            .i_Frog_X  (i_Frog_X),
            .i_Frog_Y  (i_Frog_Y),
            .o_Car_X   (o_Car_X[g*POS_W +: POS_W]),
            .o_Car_Y   (o_Car_Y[g*POS_W +: POS_W]),
            .o_Match   (match[g]),
            .o_Hit     (o_Hit_Mask[g])
        );
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            o_Hit <= 1'b0;
        else
            o_Hit <= |match;
    end

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
module tb_lane_traffic_ctrl;

    localparam int NC = 8;
    localparam int PW = 6;
    localparam int RW = 4;

    logic           clk = 1'b0;
    logic           rst, run, load;
    logic [RW-1:0]  level;
    logic [NC*PW-1:0] init_x, init_y;
    logic [NC-1:0]  dir;
    logic [NC*RW-1:0] period;
    logic [PW-1:0]  frog_x, frog_y;
    logic [NC*PW-1:0] car_x, car_y;
    logic           tick, hit;
    logic [NC-1:0]  hit_mask;

    int checks = 0;
    int passed = 0;

    lane_traffic_ctrl #(
        .NUM_CARS     (NC),
        .GRID_W       (40),
        .POS_W        (PW),
        .PER_W        (RW),
        .TICK_W       (26),
        .c_TICK_COUNT (4)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Run      (run),
        .i_Load     (load),
        .i_Level    (level),
        .i_Init_X   (init_x),
        .i_Init_Y   (init_y),
        .i_Dir      (dir),
        .i_Period   (period),
        .i_Frog_X   (frog_x),
        .i_Frog_Y   (frog_y),
        .o_Car_X    (car_x),
        .o_Car_Y    (car_y),
        .o_Tick     (tick),
        .o_Hit      (hit),
        .o_Hit_Mask (hit_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          adv;
        logic        run;
        logic [3:0]  level;
        logic        tick;
        int          x0, x1, x2;
        logic        hit;
    } vec_t;

    vec_t tbl[11];

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int cx(input int i);
        return int'(car_x[i*PW +: PW]);
    endfunction

    function automatic int cy(input int i);
        return int'(car_y[i*PW +: PW]);
    endfunction

    initial begin
        // car0: X=38 right period0; car1: X=1 left period2; car2: (4,13) right period0
        for (int i = 0; i < NC; i++) begin
            init_x[i*PW +: PW] = PW'(10 + i);
            init_y[i*PW +: PW] = PW'(i);
            period[i*RW +: RW] = 4'd15;
            dir[i] = 1'b0;
        end
        init_x[0*PW +: PW] = 6'd38; init_y[0*PW +: PW] = 6'd2;  period[0*RW +: RW] = 4'd0;
        init_x[1*PW +: PW] = 6'd1;  init_y[1*PW +: PW] = 6'd3;  period[1*RW +: RW] = 4'd2; dir[1] = 1'b1;
        init_x[2*PW +: PW] = 6'd4;  init_y[2*PW +: PW] = 6'd13; period[2*RW +: RW] = 4'd0;
        frog_x = 6'd5; frog_y = 6'd13;
        level = '0; load = 1'b0; run = 1'b1; rst = 1'b1;

        tbl[0]  = '{3, 1'b1, 4'd0, 1'b0, 38,  1,  4, 1'b0};
        tbl[1]  = '{1, 1'b1, 4'd0, 1'b1, 39,  1,  5, 1'b0};
        tbl[2]  = '{1, 1'b1, 4'd0, 1'b0, 39,  1,  5, 1'b1};
        tbl[3]  = '{3, 1'b1, 4'd0, 1'b1,  0,  1,  6, 1'b1};
        tbl[4]  = '{1, 1'b1, 4'd0, 1'b0,  0,  1,  6, 1'b0};
        tbl[5]  = '{3, 1'b1, 4'd0, 1'b1,  1,  0,  7, 1'b0};
        tbl[6]  = '{4, 1'b1, 4'd0, 1'b1,  2,  0,  8, 1'b0};
        tbl[7]  = '{4, 1'b1, 4'd0, 1'b1,  3,  0,  9, 1'b0};
        tbl[8]  = '{4, 1'b1, 4'd0, 1'b1,  4, 39, 10, 1'b0};
        tbl[9]  = '{4, 1'b1, 4'd5, 1'b1,  5, 38, 11, 1'b0};
        tbl[10] = '{4, 1'b1, 4'd5, 1'b1,  6, 37, 12, 1'b0};

        step(1);
        rst = 1'b0;
        check("rst_tick", int'(tick), 0);
        check("rst_x0", cx(0), 38);
        check("rst_y0", cy(0), 2);
        check("rst_x1", cx(1), 1);
        check("rst_y2", cy(2), 13);
        check("rst_hit", int'(hit), 0);
        check("rst_mask", int'(hit_mask), 0);

        // Wrap, period and level speed-up, and frog collision timing
        for (int v = 0; v < 11; v++) begin
            run = tbl[v].run;
            level = tbl[v].level;
            step(tbl[v].adv);
            check($sformatf("v%0d_tick", v), int'(tick), int'(tbl[v].tick));
            check($sformatf("v%0d_x0", v), cx(0), tbl[v].x0);
            check($sformatf("v%0d_x1", v), cx(1), tbl[v].x1);
            check($sformatf("v%0d_x2", v), cx(2), tbl[v].x2);
            check($sformatf("v%0d_hit", v), int'(hit), int'(tbl[v].hit));
            check($sformatf("v%0d_mask", v), int'(hit_mask), tbl[v].hit ? 4 : 0);
        end

        // Pause mid-count: counter holds at 2, nothing moves
        step(2);
        run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("pause_tick", int'(tick), 0);
            check("pause_x0", cx(0), 6);
        end
        run = 1'b1;
        step(1);
        check("resume_no_tick", int'(tick), 0);
        step(1);
        check("resume_tick", int'(tick), 1);
        check("resume_x0", cx(0), 7);
        check("resume_x1", cx(1), 36);
        check("resume_x2", cx(2), 13);

        // Load on the cycle a tick would fire
        step(3);
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("load_tick", int'(tick), 0);
        check("load_x0", cx(0), 38);
        check("load_x1", cx(1), 1);
        check("load_x2", cx(2), 4);
        check("load_y1", cy(1), 3);
        step(3);
        check("load_no_tick", int'(tick), 0);
        check("load_hold_x0", cx(0), 38);
        step(1);
        check("load_next_tick", int'(tick), 1);
        check("load_next_x0", cx(0), 39);
        check("load_next_x1", cx(1), 0);

        // Out-of-range init X: right wraps to 0, left wraps to GRID_W-1
        init_x[0*PW +: PW] = 6'd45;
        init_x[1*PW +: PW] = 6'd45;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("oor_load_x0", cx(0), 45);
        step(4);
        check("oor_tick", int'(tick), 1);
        check("oor_right", cx(0), 0);
        check("oor_left", cx(1), 39);
        check("oor_x2", cx(2), 5);
        step(1);
        check("pre_rst_hit", int'(hit), 1);

        // Reset mid-run
        init_x[0*PW +: PW] = 6'd20;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_x0", cx(0), 20);
        check("mrst_x2", cx(2), 4);
        check("mrst_tick", int'(tick), 0);
        check("mrst_hit", int'(hit), 0);
        check("mrst_mask", int'(hit_mask), 0);
        step(3);
        check("mrst_no_tick", int'(tick), 0);
        step(1);
        check("mrst_tick1", int'(tick), 1);
        check("mrst_step_x0", cx(0), 21);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
